// File: rtl/seq_calc_acc.sv
// Sequential two-operand calculator with optional result chaining (running accumulator).
// Operands are signed; results are WIDTH+1 wide with wrap or saturate on overflow.
module seq_calc_acc #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned SAT   = 0,
    parameter int unsigned CHAIN = 1
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             clr,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    output logic [WIDTH:0]   out,
    output logic             out_valid,
    output logic             ovf,
    output logic             A_out,
    output logic             B_out
);

    localparam int unsigned OW = WIDTH + 1;
    localparam int unsigned RW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        EXEC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state, state_d;
    logic [OW-1:0]        a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [1:0]           op_q, op_d;
    logic [OW-1:0]        out_d;
    logic                 out_valid_d, ovf_d, a_out_d, b_out_d, in_ready_d;

    logic signed [RW-1:0] a_ext, b_ext, r_exact;
    logic [OW-1:0]        res;
    logic                 res_ovf;
    logic                 xfer;

    assign xfer = in_valid & in_ready;

    // Exact result in WIDTH+2 bits; it fits WIDTH+1 bits when the top two bits agree.
    always_comb begin
        a_ext   = RW'($signed(a_q));
        b_ext   = RW'($signed(b_q));
        r_exact = '0;
        case (op_q)
            2'b00:   r_exact = a_ext + b_ext;
            2'b01:   r_exact = a_ext - b_ext;
            2'b10:   r_exact = (a_ext >= b_ext) ? a_ext : b_ext;
            default: r_exact = (a_ext <= b_ext) ? a_ext : b_ext;
        endcase
        res_ovf = r_exact[RW-1] != r_exact[RW-2];
        res     = r_exact[OW-1:0];
        if (res_ovf && (SAT != 0)) begin
            res = r_exact[RW-1] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, {WIDTH{1'b1}}};
        end
    end

    // Next-state and next-output logic; everything holds unless a transition says otherwise.
    always_comb begin
        state_d     = state;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_d       = out;
        ovf_d       = ovf;
        out_valid_d = 1'b0;
        a_out_d     = A_out;
        b_out_d     = B_out;

        case (state)
            IDLE: begin
                if (xfer) begin
                    a_d     = OW'($signed(in));
                    a_out_d = 1'b1;
                    state_d = HAVE_A;
                end
            end
            HAVE_A: begin
                if (xfer) begin
                    b_d     = in;
                    op_d    = op;
                    b_out_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_d       = res;
                ovf_d       = res_ovf;
                out_valid_d = 1'b1;
                b_out_d     = 1'b0;
                state_d     = DONE;
            end
            default: begin
                if (xfer) begin
                    if (CHAIN != 0) begin
                        a_d     = out;
                        b_d     = in;
                        op_d    = op;
                        b_out_d = 1'b1;
                        state_d = EXEC;
                    end else begin
                        a_d     = OW'($signed(in));
                        state_d = HAVE_A;
                    end
                end
            end
        endcase

        // Clear wins over everything, including an operand offered in the same cycle.
        if (clr) begin
            state_d     = IDLE;
            out_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            a_out_d     = 1'b0;
            b_out_d     = 1'b0;
        end

        in_ready_d = (state_d != EXEC);
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 2'b00;
            out       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            A_out     <= 1'b0;
            B_out     <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            out       <= out_d;
            ovf       <= ovf_d;
            out_valid <= out_valid_d;
            A_out     <= a_out_d;
            B_out     <= b_out_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule
